// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared state encoding and line-level constants for the shreg receiver
package shreg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAR  = 3'd2,
    STOP = 3'd3,
    BRK  = 3'd4
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/shreg_rx_out.sv
// rtl/shreg_rx_out.sv - single-entry output holding register with valid/ready and overrun pulse
module shreg_rx_out #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         ovr
);

  logic [W-1:0] q_q, q_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  logic         accept;

  // A full register frees up on the same edge it is consumed, so a new word can replace it.
  assign accept = load & (~valid_q | ready);

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = load & valid_q & ~ready;
    if (accept) begin
      q_d     = din;
      valid_d = 1'b1;
    end else if (valid_q & ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign ovr   = ovr_q;

endmodule

// File: rtl/shreg_rx.sv
// rtl/shreg_rx.sv - serial frame receiver: start, W data bits MSB first, optional even parity, stop
// Optional parity bit enabled by defining SHREG_RX_PARITY_EN.
module shreg_rx
  import shreg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         si,
  input  logic         bit_en,
  output logic [W-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic         ferr,
  output logic         perr,
  output logic         ovr
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic          load;
`ifdef SHREG_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    load    = 1'b0;
`ifdef SHREG_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (si == START_BIT) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          shift_d = {shift_q[W-2:0], si};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
`ifdef SHREG_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SHREG_RX_PARITY_EN
        PAR: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = ^{shift_q, si};
          state_d   = STOP;
        end
`endif
        STOP: begin
          if (si == STOP_BIT) begin
            state_d = IDLE;
`ifdef SHREG_RX_PARITY_EN
            if (par_bad_q) perr_d = 1'b1;
            else           load   = 1'b1;
`else
            load = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
        BRK: begin
          // Only a return to the idle level re-arms start detection.
          if (si == IDLE_LEVEL) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef SHREG_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef SHREG_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign ferr = ferr_q;
`ifdef SHREG_RX_PARITY_EN
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  shreg_rx_out #(.W(W)) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (shift_q),
    .ready (ready),
    .q     (q),
    .valid (valid),
    .ovr   (ovr)
  );

endmodule

// File: doc/shreg_rx.md
# shreg_rx

Serial frame receiver that sits directly downstream of the 8-bit shift register and consumes its `so` bit stream. It detects a start bit, shifts in `W` data bits MSB first, checks the stop bit (and optional parity bit), then presents the byte on a valid/ready output port. It turns the shift register's serial output back into parallel words for the next stage.

## Interface
- `W`, default 8: data bits per frame; bit counter is `$clog2(W)` wide.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `si  in  1`: serial line, driven from the shift register `so`; idles high.
- `bit_en  in  1`: bit strobe. `si` is sampled only on edges where `bit_en=1`. Tie it to 1 for one bit per clock.
- `q  out  W`: received word; stable while `valid=1`.
- `valid  out  1`: `q` holds an unconsumed word.
- `ready  in  1`: consumer accepts `q` on an edge where `valid & ready`.
- `ferr  out  1`: one-cycle pulse when a bad stop bit (`0`) is sampled.
- `perr  out  1`: one-cycle pulse on parity mismatch. Constant 0 when parity is compiled out.
- `ovr  out  1`: one-cycle pulse when a good frame is dropped because the output is still full.

## Operation
- States: `IDLE`, `DATA`, `PAR`, `STOP`, `BRK`.
- `IDLE`: on a sampled `si=0` (start bit), clear the bit counter and go to `DATA`. A sampled `si=1` stays in `IDLE`.
- `DATA`: shift left, with `shift <= {shift[W-2:0], si}`, so the first data bit lands in the MSB. After `W` samples go to `PAR`, or to `STOP` when parity is compiled out.
- `PAR`: sample the parity bit, latch the mismatch flag, go to `STOP`.
- `STOP`, sampled `si=1`:
  - Parity OK and `valid=0`: frame accepted.
  - Parity OK and `valid=1`: frame accepted only if `ready=1` on the same edge.
  - Accepted: load `q <= shift`, set `valid=1`, go to `IDLE`.
  - Parity OK, `valid=1`, `ready=0`: pulse `ovr`, keep the old `q`, go to `IDLE`.
  - Parity bad: pulse `perr`, discard the frame, go to `IDLE`; `ovr` is not raised.
- `STOP`, sampled `si=0`: pulse `ferr`, discard the frame, go to `BRK`.
- `BRK`: wait for a sampled `si=1`, then go to `IDLE`. A line held low never produces a false start.
- Handshake: `valid` falls on the edge with `valid & ready`, unless a new frame loads on the same edge. In that case `valid` stays 1 and `q` takes the new word.
- `ready` with `valid=0` has no effect.
- `bit_en=0`: state, counter and shift register all hold. The handshake still operates on every clock.

## Timing
- Reset values: `q=0`, `valid=0`, `ferr=0`, `perr=0`, `ovr=0`; state `IDLE`, counter 0, shift register 0.
- Reset asserted mid-frame aborts the frame at once, with no pulse on any error output.
- Latency with `bit_en=1` every clock:
  - `valid` rises on the edge that samples the stop bit.
  - That is `W+2` edges after the start-bit sample edge, or `W+1` without parity.
- Error pulses last exactly one cycle: asserted on the stop-bit (or `BRK`-entry) edge, cleared on the next edge.
- Back-to-back frames: a start bit may be sampled on the edge right after the stop bit, with no idle gap required.
- Maximum sustained throughput is one word per `W+3` strobes with parity, `W+2` without.

## Configuration
- Macro `SHREG_RX_PARITY_EN`.
- Defined: the `PAR` state exists. An even-parity bit follows the data bits: the XOR of the `W` data bits and the parity bit must be 0.
- Undefined: the `PAR` state and the parity flag are removed, `DATA` goes directly to `STOP`, and `perr` is tied to 0.

## Structure
- Shared package `shreg_pkg`: state enum `rx_state_t` (`IDLE`, `DATA`, `PAR`, `STOP`, `BRK`) and constants `START_BIT=1'b0`, `STOP_BIT=1'b1`, `IDLE_LEVEL=1'b1`.
- One natural sub-module, `shreg_rx_out`: the single-entry output holding register with the valid/ready logic and overrun detection. The FSM and shift register stay in the top.

## Test plan
1. Parity off, `bit_en=1`. Send start 0, data `01111111`, stop 1; `ready=0` -> `valid=1` with `q=8'h7F` on the stop-sample edge; `ready=1` one cycle later -> `valid=0`.
2. Two back-to-back frames `8'hA5` then `8'h3C`, `ready` held 0 -> `q=8'hA5` kept, one `ovr` pulse at the second stop bit.
3. Same two frames with `ready=1` on the second stop-bit edge -> `q=8'h3C`, `valid` stays 1, no `ovr`.
4. Frame `8'h81` with stop bit 0, then `si` held 0 for 5 bits, then 1 -> one `ferr` pulse, no `valid`, no restart until `si=1` is sampled.
5. Parity on: frame `8'h01` with parity 1 -> `valid`, `q=8'h01`. Same frame with parity 0 -> one `perr` pulse, `valid` stays 0.
6. `bit_en` toggling 1/0 each clock during frame `8'h55` -> same `q=8'h55`, latency doubled. Assert `rst` after 4 data bits -> all outputs 0, next frame `8'hF0` received correctly.
